// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus: TXDATA stores feed a small
// FIFO that is serialised on tx; STATUS reports full/busy/count/overflow.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 52,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  output logic [31:0] read_data,
  output logic        tx
);

  localparam int unsigned      PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned      BaudW    = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLoad = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]       DepthCnt = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [4:0]        count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic       sel, wr_txdata, wr_status, status_rd;
  logic       full, empty, busy, push, pop, baud_last;
  logic [2:0] count_sat;
  logic       unused_bits;

  assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata = memwrite & sel & ~addr[2];
  assign wr_status = memwrite & sel & addr[2];
  assign status_rd = memread & sel & addr[2];
  assign full      = (count_q == DepthCnt);
  assign empty     = (count_q == 5'd0);
  assign busy      = (state_q != StIdle);
  assign push      = wr_txdata & ~full;
  assign baud_last = (baud_q == '0);
  assign unused_bits = ^{addr[1:0], write_data[31:8]};

  // tx_d is the line level for the state being entered, so tx stays a clean flop output.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        pop  = ~empty;
      end
      StStart: begin
        if (baud_last) begin
          state_d = StData;
          bit_d   = 3'd0;
          baud_d  = BaudLoad;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = BaudLoad;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        if (baud_last) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
    endcase
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      baud_d  = BaudLoad;
      state_d = StStart;
      tx_d    = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (wr_status) begin
      overflow_d = 1'b0;
    end else if (wr_txdata && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      count_q    <= 5'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= write_data[7:0];
    end
  end

  assign count_sat = (count_q > 5'd7) ? 3'd7 : count_q[2:0];
  assign read_data = status_rd ? {26'd0, overflow_q, count_sat, busy, full} : 32'd0;
  assign tx        = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model checked every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_mmio_uart_tx;

  localparam logic [31:0] Base  = 32'h0000_1000;
  localparam int          Cpb   = 4;
  localparam int          Depth = 4;
  localparam int          Frame = 10 * Cpb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] read_data;
  logic        tx;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  mmio_uart_tx #(
    .BASE_ADDR   (Base),
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr      (addr),
    .write_data(write_data),
    .memwrite  (memwrite),
    .memread   (memread),
    .read_data (read_data),
    .tx        (tx)
  );

  initial forever #5 clk = ~clk;

  // Reference model: queued bytes, overflow flag and cycles left in the current frame.
  logic [7:0] mq[$];
  bit         m_ovf  = 1'b0;
  int         m_left = 0;
  logic [7:0] m_byte = 8'd0;

  function automatic bit in_window(input logic [31:0] a);
    return (a[31:3] == Base[31:3]);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_left = 0;
    end else begin
      automatic bit was_full = (mq.size() == Depth);
      if ((m_left <= 1) && (mq.size() > 0)) begin
        m_byte = mq.pop_front();
        m_left = Frame;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (memwrite && in_window(addr) && !addr[2]) begin
        if (was_full) m_ovf = 1'b1;
        else mq.push_back(write_data[7:0]);
      end
      if (memwrite && in_window(addr) && addr[2]) m_ovf = 1'b0;
    end
  end

  function automatic logic exp_tx();
    int pos;
    if (m_left == 0) return 1'b1;
    pos = (Frame - m_left) / Cpb;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_byte[pos-1];
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [2:0] cnt;
    if (!(memread && in_window(addr) && addr[2])) return 32'd0;
    cnt = (mq.size() > 7) ? 3'd7 : 3'(mq.size());
    return {26'd0, m_ovf, cnt, (m_left > 0), (mq.size() == Depth)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, half a clock away from the active edge.
  initial forever begin
    @(negedge clk);
    cycle++;
    check("tx_model", {31'd0, tx}, {31'd0, exp_tx()});
    check("read_data_model", read_data, exp_rd());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    write_data = d;
    memwrite = 1'b1;
    step();
    memwrite = 1'b0;
    addr = 32'd0;
    write_data = 32'd0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    memread = 1'b1;
    @(negedge clk);
    #1;
    d = read_data;
    step();
    memread = 1'b0;
    addr = 32'd0;
  endtask

  logic [31:0] rd;
  logic [9:0]  pat;

  initial begin
    #2 reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    // Idle after reset.
    repeat (100) step();
    check("idle_tx", {31'd0, tx}, 32'd1);
    load(Base + 32'd4, rd);
    check("idle_status", rd, 32'h00);

    // Single 0xA5 frame, STATUS polled throughout.
    store(Base, 32'h0000_00A5);
    check("idle_latency_tx", {31'd0, tx}, 32'd1);
    addr = Base + 32'd4;
    memread = 1'b1;
    step();
    pat = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      check($sformatf("a5_bit%0d", b), {31'd0, tx}, {31'd0, pat[b]});
      if (b == 5) check("a5_busy_status", read_data, 32'h02);
      repeat (Cpb) step();
    end
    memread = 1'b0;
    check("a5_after_tx", {31'd0, tx}, 32'd1);
    load(Base + 32'd4, rd);
    check("a5_after_status", rd, 32'h00);

    // Three back-to-back stores.
    store(Base, 32'h01);
    store(Base, 32'h02);
    store(Base, 32'h03);
    load(Base + 32'd4, rd);
    check("three_count2", rd, 32'h0A);
    repeat (37) step();
    check("three_stop1", {31'd0, tx}, 32'd1);
    step();
    check("three_no_gap", {31'd0, tx}, 32'd0);
    repeat (81) step();
    check("three_done_tx", {31'd0, tx}, 32'd1);
    load(Base + 32'd4, rd);
    check("three_done_status", rd, 32'h00);

    // Overflow: six stores into a four-deep FIFO.
    for (int i = 0; i < 6; i++) store(Base, 32'h10 + i);
    load(Base + 32'd4, rd);
    check("ovf_status", rd, 32'h33);
    store(Base + 32'd4, 32'hFFFF_FFFF);
    load(Base + 32'd4, rd);
    check("ovf_cleared", rd, 32'h13);
    repeat (200) step();
    check("ovf_done_tx", {31'd0, tx}, 32'd1);
    load(Base + 32'd4, rd);
    check("ovf_done_status", rd, 32'h00);

    // Reset in the middle of data bit 3 with a second byte queued.
    store(Base, 32'h00);
    store(Base, 32'h55);
    repeat (17) step();
    check("pre_reset_bit3", {31'd0, tx}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("reset_abort_tx", {31'd0, tx}, 32'd1);
    step();
    step();
    reset_n = 1'b1;
    load(Base + 32'd4, rd);
    check("reset_status", rd, 32'h00);
    repeat (60) step();
    check("reset_no_resume", {31'd0, tx}, 32'd1);

    // Addresses outside the window and ignored low address bits.
    load(Base + 32'd8, rd);
    check("outside_read", rd, 32'h0);
    store(Base + 32'd8, 32'h77);
    repeat (5) step();
    check("outside_tx", {31'd0, tx}, 32'd1);
    load(Base + 32'd4, rd);
    check("outside_status", rd, 32'h00);
    load(Base + 32'd3, rd);
    check("txdata_read_b3", rd, 32'h0);
    load(Base + 32'd7, rd);
    check("status_read_b7", rd, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
